// File: rtl/mox_pkg.sv
// Shared definitions for the mox125 front end.
//   - LEN_2B/LEN_4B/LEN_6B: instruction length codes, in 16-bit parcels.
//   - fetch_state_e: fetch stage state encodings.
//   - fetch_entry_t: one 82-bit fetch queue entry {pc, inst, imm, len}.
//   - inst_len(): opcode length table.
package mox_pkg;

  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_4B = 2'd2;
  localparam logic [1:0] LEN_6B = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] inst;
    logic [31:0] imm;
    logic [1:0]  len;
  } fetch_entry_t;

  // Form 2/3 (bit 15 set) is always a single parcel. Form 1 length depends
  // on the major opcode in bits [15:8].
  function automatic logic [1:0] inst_len(input logic [15:0] inst);
    logic [1:0] len;
    len = LEN_2B;
    if (!inst[15]) begin
      case (inst[15:8])
        8'h01, 8'h03, 8'h08, 8'h09, 8'h1a, 8'h1b,
        8'h1d, 8'h1f, 8'h20, 8'h22, 8'h24, 8'h30: len = LEN_6B;
        8'h0c, 8'h0d, 8'h36, 8'h37, 8'h38, 8'h39: len = LEN_4B;
        default:                                  len = LEN_2B;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Circular buffer of decoded fetch entries between fetch and decode.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write wdata_i at the tail (ignored when full)
//   pop_i        : advance the head (ignored when empty)
//   flush_i      : empty the queue; overrides push and pop
//   rdata_o      : head entry, all zero while empty
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_queue
  import mox_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t wdata_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after
  // it has been written, and the zeroed empty output hides stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifetch.sv
// mox125 instruction fetch stage, directly downstream of the icache.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   ic_adr_o, ic_stb_o     : fetch request to icache (address = pc)
//   ic_hit_i, ic_inst_i,
//   ic_data_i              : combinational icache response
//   redirect_i,
//   redirect_pc_i          : branch/exception redirect; flushes the queue
//   valid_o, ready_i       : head handshake with decode
//   inst_o, imm_o, pc_o,
//   len_o                  : head entry (zero while empty)
// Optional macro IFETCH_PERF_EN adds saturating counters perf_miss_o
// (cycles stalled on a miss) and perf_fetch_o (instructions pushed).
module ifetch
  import mox_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] ic_adr_o,
  output logic        ic_stb_o,
  input  logic        ic_hit_i,
  input  logic [15:0] ic_inst_i,
  input  logic [31:0] ic_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] inst_o,
  output logic [31:0] imm_o,
  output logic [31:0] pc_o,
  output logic [1:0]  len_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_miss_o,
  output logic [31:0] perf_fetch_o
`endif
);

  logic [31:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;
  logic         full, empty, push, pop;
  logic [1:0]   len;
  logic [31:0]  imm;
  fetch_entry_t wr_entry, head;

  // Full blocks the request even when decode pops this cycle, keeping
  // ready_i out of the stb path.
  assign ic_adr_o = pc_q;
  assign ic_stb_o = ~rst_i & ~full & ~redirect_i;
  assign push     = ic_stb_o & ic_hit_i;
  assign pop      = ~empty & ready_i & ~redirect_i;
  assign valid_o  = ~empty;

  assign len = inst_len(ic_inst_i);

  always_comb begin
    imm = '0;
    case (len)
      LEN_6B:  imm = ic_data_i;
      LEN_4B:  imm = {16'h0, ic_data_i[31:16]};
      default: imm = '0;
    endcase
  end

  assign wr_entry = '{pc: pc_q, inst: ic_inst_i, imm: imm, len: len};

  // Next pc advances by 2*len bytes; 32-bit wrap is intentional.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i)  pc_d = redirect_pc_i & ~32'h1;
    else if (push)   pc_d = pc_q + {29'd0, len, 1'b0};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (ic_stb_o && !ic_hit_i) state_d = ST_STALL;
      ST_STALL: if (ic_hit_i) state_d = ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (redirect_i) state_d = ST_FLUSH;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_VECTOR;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign inst_o = head.inst;
  assign imm_o  = head.imm;
  assign pc_o   = head.pc;
  assign len_o  = head.len;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_miss_q, perf_miss_d;
  logic [31:0] perf_fetch_q, perf_fetch_d;

  // A miss cycle is one where a request is outstanding without a hit.
  always_comb begin
    perf_miss_d  = perf_miss_q;
    perf_fetch_d = perf_fetch_q;
    if (ic_stb_o && !ic_hit_i && perf_miss_q != '1) perf_miss_d = perf_miss_q + 32'd1;
    if (push && perf_fetch_q != '1) perf_fetch_d = perf_fetch_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_miss_q  <= '0;
      perf_fetch_q <= '0;
    end else begin
      perf_miss_q  <= perf_miss_d;
      perf_fetch_q <= perf_fetch_d;
    end
  end

  assign perf_miss_o  = perf_miss_q;
  assign perf_fetch_o = perf_fetch_q;
`endif

endmodule
